// File: rtl/ts_pkg.sv
// Shared constants, serializer state type and sync-byte helper for the TS word-to-byte converter.
package ts_pkg;

    localparam int TS_WORD_W    = 33;
    localparam int TS_BYTE_W    = 9;
    localparam int TS_PKT_BYTES = 188;
    localparam int TS_PKT_WORDS = 47;

    localparam logic [7:0] TS_SYNC_BYTE = 8'h47;

    typedef enum logic [2:0] {
        IDLE,
        BYTE0,
        BYTE1,
        BYTE2,
        BYTE3
    } ser_state_e;

    // A SOP word whose leading byte is not the TS sync byte marks a corrupted packet start.
    function automatic logic is_bad_sync(input logic [TS_WORD_W-1:0] word);
        return word[TS_WORD_W-1] && (word[31:24] != TS_SYNC_BYTE);
    endfunction

endpackage

// File: rtl/ts_word_fifo.sv
// Single-clock show-ahead FIFO for 33-bit TS words; a write while full is accepted only alongside a read.
module ts_word_fifo
    import ts_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int FIFO_AW    = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [TS_WORD_W-1:0] wr_data,
    input  logic                 rd_en,
    output logic [TS_WORD_W-1:0] rd_data,
    output logic                 full,
    output logic                 empty,
    output logic [FIFO_AW:0]     count
);

    localparam logic [FIFO_AW:0] DEPTH_CNT = FIFO_DEPTH[FIFO_AW:0];

    logic [TS_WORD_W-1:0] mem_q [FIFO_DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]     count_q, count_d;
    logic                 do_wr, do_rd;

    assign full    = (count_q == DEPTH_CNT);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments; reset is synchronous and active-low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; the pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/ts_32to8.sv
// TS 33-bit word stream to 9-bit byte stream serializer behind a word FIFO.
// Define TS_SYNC_CHECK_EN to drop packets whose SOP word lacks the 0x47 sync byte.
module ts_32to8
    import ts_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int FIFO_AW    = 3
) (
    input  logic                 clk_main,
    input  logic                 rst_n,
    input  logic [TS_WORD_W-1:0] ts_din,
    input  logic                 ts_din_en,
    output logic                 ts_din_rdy,
    output logic [TS_BYTE_W-1:0] ts_dout,
    output logic                 ts_dout_en,
    output logic                 ovf,
    output logic                 sync_err
);

    logic [TS_WORD_W-1:0] fifo_rd_data;
    logic                 fifo_full, fifo_empty, pop;
    logic [FIFO_AW:0]     unused_fifo_count;

    ser_state_e           state_q, state_d;
    logic [TS_WORD_W-1:0] shift_q, shift_d;
    logic [TS_BYTE_W-1:0] dout_q, dout_d;
    logic                 dout_en_q, dout_en_d;
    logic                 ovf_q, ovf_d;
`ifdef TS_SYNC_CHECK_EN
    logic                 sync_err_q, sync_err_d;
    logic                 discard_q, discard_d;
`endif

    ts_word_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .FIFO_AW    (FIFO_AW)
    ) u_fifo (
        .clk     (clk_main),
        .rst_n   (rst_n),
        .wr_en   (ts_din_en && ts_din_rdy),
        .wr_data (ts_din),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (unused_fifo_count)
    );

    assign ts_din_rdy = !fifo_full;
    assign ts_dout    = dout_q;
    assign ts_dout_en = dout_en_q;
    assign ovf        = ovf_q;
`ifdef TS_SYNC_CHECK_EN
    assign sync_err   = sync_err_q;
`else
    assign sync_err   = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        dout_d    = '0;
        dout_en_d = 1'b0;
        pop       = 1'b0;
        ovf_d     = ovf_q | (ts_din_en & ~ts_din_rdy);
`ifdef TS_SYNC_CHECK_EN
        sync_err_d = 1'b0;
        discard_d  = discard_q;
`endif
        case (state_q)
            BYTE0: begin
                dout_d    = {shift_q[32], shift_q[31:24]};
                dout_en_d = 1'b1;
                state_d   = BYTE1;
            end
            BYTE1: begin
                dout_d    = {1'b0, shift_q[23:16]};
                dout_en_d = 1'b1;
                state_d   = BYTE2;
            end
            BYTE2: begin
                dout_d    = {1'b0, shift_q[15:8]};
                dout_en_d = 1'b1;
                state_d   = BYTE3;
            end
            default: begin
                // IDLE and BYTE3 share the pop decision so back-to-back words leave no gap.
                if (state_q == BYTE3) begin
                    dout_d    = {1'b0, shift_q[7:0]};
                    dout_en_d = 1'b1;
                end
                state_d = IDLE;
                if (!fifo_empty) begin
                    pop = 1'b1;
`ifdef TS_SYNC_CHECK_EN
                    if (is_bad_sync(fifo_rd_data)) begin
                        sync_err_d = 1'b1;
                        discard_d  = 1'b1;
                    end else if (!discard_q || fifo_rd_data[32]) begin
                        discard_d = 1'b0;
                        shift_d   = fifo_rd_data;
                        state_d   = BYTE0;
                    end
`else
                    shift_d = fifo_rd_data;
                    state_d = BYTE0;
`endif
                end
            end
        endcase
    end

    always_ff @(posedge clk_main) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            dout_q    <= '0;
            dout_en_q <= 1'b0;
            ovf_q     <= 1'b0;
`ifdef TS_SYNC_CHECK_EN
            sync_err_q <= 1'b0;
            discard_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            dout_q    <= dout_d;
            dout_en_q <= dout_en_d;
            ovf_q     <= ovf_d;
`ifdef TS_SYNC_CHECK_EN
            sync_err_q <= sync_err_d;
            discard_q  <= discard_d;
`endif
        end
    end

endmodule

// File: doc/ts_32to8.md
Name: ts_32to8

Overview:
- Width converter from the 33-bit TS word stream back to the 9-bit TS byte stream; the inverse of the byte-to-word packer.
- Word format: bit 32 = start-of-packet flag, bits 31:0 = four payload bytes, first byte in [31:24].
- Byte format: bit 8 = start-of-packet flag, bits 7:0 = byte.
- Sits between the wide internal TS datapath and byte-wide egress (GbE/ASI framer), absorbing the 4:1 rate mismatch in a small word FIFO with input backpressure.

Parameters:
- FIFO_DEPTH, 8, word FIFO depth in 33-bit words; power of two, at least 2.
- FIFO_AW, 3, FIFO address width; equals log2(FIFO_DEPTH).

Ports:
- clk_main  in  1  single system clock; all logic on the rising edge.
- rst_n  in  1  synchronous reset, active-low.
- ts_din  in  33  input word; [32] SOP, [31:0] bytes, MSB byte first.
- ts_din_en  in  1  input word valid.
- ts_din_rdy  out  1  word FIFO can accept; equals not-full.
- ts_dout  out  9  output byte; [8] SOP, [7:0] data.
- ts_dout_en  out  1  output byte valid; no backpressure.
- ovf  out  1  sticky: a word was offered while ts_din_rdy=0.
- sync_err  out  1  one-cycle pulse on a bad sync byte (feature only; otherwise 0).

Behaviour:
- Reset (rst_n=0 at an edge): FIFO pointers and count = 0; ts_din_rdy=1 on the cycle after reset; ts_dout=0; ts_dout_en=0; ovf=0; sync_err=0; serializer in IDLE.
  - Reset mid-word discards the partially shifted word and all FIFO contents.
- Write:
  - ts_din_en=1 and ts_din_rdy=1: word written at that edge.
  - ts_din_en=1 and ts_din_rdy=0: word dropped and ovf set; ovf clears only on reset.
- Simultaneous read and write when the FIFO is full is allowed; the count is unchanged and ts_din_rdy stays 0 for that cycle.
- Serializer FSM states:
  - IDLE: if FIFO not empty, pop a word into the shift register and go to BYTE0.
  - BYTE0..BYTE3: registered output ts_dout = {sop&(state==BYTE0), byte k}, ts_dout_en=1.
  - BYTE3 exit: if FIFO not empty, pop the next word and go to BYTE0 with no gap; else go to IDLE (ts_dout_en=0).
- Byte order: BYTE0 = [31:24], BYTE1 = [23:16], BYTE2 = [15:8], BYTE3 = [7:0]. The SOP bit appears only on BYTE0 of a word with [32]=1.
- Latency: a word written at edge N into an empty FIFO with the serializer IDLE gives its BYTE0 with ts_dout_en=1 after edge N+2. Its four bytes occupy edges N+2..N+5.
- Throughput: 1 byte/cycle sustained. Input is sustainable at 1 word per 4 cycles. A burst of FIFO_DEPTH+1 words at 1 word/cycle fills the FIFO without loss.
- Packet length is not checked (a 188-byte packet is 47 words); words pass unchanged.

Optional Feature:
- Macro: TS_SYNC_CHECK_EN.
- With the macro defined: when the serializer pops a word with [32]=1 and [31:24] != 8'h47:
  - sync_err pulses one cycle;
  - that word and every following word up to (not including) the next SOP word are discarded with no ts_dout_en;
  - discarding consumes one FIFO word per cycle.
- Without the macro: no check; sync_err tied to 0; all words are serialized.

Decomposition:
- Package ts_pkg:
  - TS_SYNC_BYTE = 8'h47, TS_PKT_BYTES = 188, TS_PKT_WORDS = 47;
  - TS_WORD_W = 33, TS_BYTE_W = 9;
  - serializer state enum (IDLE, BYTE0..BYTE3).
- Sub-module ts_word_fifo: synchronous single-clock FIFO, 33 bits wide, FIFO_DEPTH deep, with full/empty/count outputs. The top level holds the FSM, shift register and flags.

Test Plan:
- Single word {1, 32'h47400011} after reset → bytes 0x147, 0x040, 0x000, 0x011 on consecutive cycles, first at write edge+2; then ts_dout_en=0.
- 47-word packet (first word SOP 0x47401000, then 0x00000001..0x0000002E) at 1 word/4 cycles → 188 contiguous bytes, exactly one with bit8=1, no gaps, ovf=0.
- 12-word burst at 1 word/cycle, FIFO_DEPTH=8 → ts_din_rdy drops to 0; bench holds ts_din_en while ts_din_rdy=0 for one cycle → ovf=1, that word missing from the output, all other bytes in order.
- rst_n=0 for one edge during BYTE1 of the second of 3 buffered words → next cycle ts_dout_en=0, ts_din_rdy=1, FIFO empty; a new word afterwards serializes normally.
- TS_SYNC_CHECK_EN defined: SOP word 0x48000000 + 2 words, then SOP word 0x47000000 → one sync_err pulse, no output bytes for the first 3 words, then 0x147, 0x000, 0x000, 0x000.
- Word 0x12345678 with [32]=0 → 0x012, 0x034, 0x056, 0x078, bit8=0 throughout.
